// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared sizes, transparent colour key and requester id type for the sprite ROM arbiter
package sprite_arb_pkg;
  localparam int NREQ = 4;
  localparam int AW = 8;
  localparam int SEL_W = 3;
  localparam int DW = 12;
  localparam int ROM_LAT = 1;
  localparam logic [11:0] TRANSPARENT = 12'hFFF;
  typedef logic [$clog2(NREQ)-1:0] req_id_t;
endpackage

// File: rtl/sprite_rom_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts at ptr+1 and wraps
//   req : request vector
//   ptr : index of the last winner
//   gnt : one-hot winner (zero when nothing requests)
//   idx : winner index (0 when nothing requests)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] c;
  logic hit;
  always_comb begin
    c = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      c = IW'((int'(ptr) + k) % N);
      if (!hit && req[c]) begin
        hit = 1'b1;
        idx = c;
      end
    end
    gnt = hit ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sprite_rom_arb.sv
// sprite_rom_arb: round-robin arbiter sharing one synchronous sprite ROM among icon requesters
//   clk, reset (sync, active-low), arb_en : clock, reset, grant enable
//   req / req_addr / req_sel              : per-requester request, packed pixel address and sprite select
//   gnt                                   : one-hot combinational grant
//   rom_en / rom_addr / rom_rdata         : registered ROM read port {sel,addr} and its read data
//   rsp_valid / rsp_id / rsp_data         : response strobe, owner and pixel, ROM_LAT+1 cycles after grant
//   rsp_transparent                       : response pixel equals TRANSPARENT
//   SPRITE_ARB_PRIO_EN                    : when defined, requester 0 has fixed priority over the RR ring
module sprite_rom_arb #(
  parameter int NREQ = sprite_arb_pkg::NREQ,
  parameter int AW = sprite_arb_pkg::AW,
  parameter int SEL_W = sprite_arb_pkg::SEL_W,
  parameter int DW = sprite_arb_pkg::DW,
  parameter int ROM_LAT = sprite_arb_pkg::ROM_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arb_en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*SEL_W-1:0]   req_sel,
  output logic [NREQ-1:0]         gnt,
  output logic                    rom_en,
  output logic [SEL_W+AW-1:0]     rom_addr,
  input  logic [DW-1:0]           rom_rdata,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DW-1:0]           rsp_data,
  output logic                    rsp_transparent
);
  import sprite_arb_pkg::*;
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req_m, pick_req, pick_gnt;
  logic [IW-1:0] ptr, pick_idx, gidx;
  logic ptr_ld;
  logic [ROM_LAT:0] vpipe;
  logic [ROM_LAT:0][IW-1:0] ipipe;
  assign req_m = (reset && arb_en) ? req : '0;
  rr_pick #(.N(NREQ)) u_pick (
    .req(pick_req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
`ifdef SPRITE_ARB_PRIO_EN
  // requester 0 bypasses the ring, so its wins must not move the pointer
  assign pick_req = req_m & ~NREQ'(1);
  assign gnt = req_m[0] ? NREQ'(1) : pick_gnt;
  assign gidx = req_m[0] ? '0 : pick_idx;
  assign ptr_ld = !req_m[0] && |pick_gnt;
`else
  assign pick_req = req_m;
  assign gnt = pick_gnt;
  assign gidx = pick_idx;
  assign ptr_ld = |pick_gnt;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      ptr <= IW'(NREQ - 1);
      rom_addr <= '0;
      vpipe <= '0;
      ipipe <= '0;
    end else begin
      if (ptr_ld) ptr <= pick_idx;
      if (|gnt) rom_addr <= {req_sel[gidx*SEL_W +: SEL_W], req_addr[gidx*AW +: AW]};
      vpipe[0] <= |gnt;
      ipipe[0] <= gidx;
      for (int i = 1; i <= ROM_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        ipipe[i] <= ipipe[i-1];
      end
    end
  // stage 0 is the ROM read cycle; the last stage lines up with rom_rdata
  assign rom_en = vpipe[0];
  assign rsp_valid = vpipe[ROM_LAT];
  assign rsp_id = ipipe[ROM_LAT];
  assign rsp_data = rsp_valid ? rom_rdata : '0;
  assign rsp_transparent = rsp_valid && rom_rdata == DW'(TRANSPARENT);
endmodule

// File: tb/tb_sprite_rom_arb.sv
// tb_sprite_rom_arb: directed scoreboard bench for sprite_rom_arb
module tb_sprite_rom_arb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arb_en = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] addr_a [4];
  logic [2:0] sel_a [4];
  logic [31:0] req_addr;
  logic [11:0] req_sel;
  logic [3:0] gnt;
  logic rom_en;
  logic [10:0] rom_addr;
  logic [11:0] rom_rdata;
  logic [11:0] rom_q = '0;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [11:0] rsp_data;
  logic rsp_transparent;
  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  typedef struct {int due; logic [1:0] id; logic [11:0] data; logic tr;} rsp_t;
  typedef struct {int due; logic [10:0] a;} ra_t;
  rsp_t rq[$];
  ra_t aq[$];
  rsp_t er;
  ra_t ea;

  assign req_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign req_sel = {sel_a[3], sel_a[2], sel_a[1], sel_a[0]};
  assign rom_rdata = rom_q;

  sprite_rom_arb dut (
    .clk(clk),
    .reset(reset),
    .arb_en(arb_en),
    .req(req),
    .req_addr(req_addr),
    .req_sel(req_sel),
    .gnt(gnt),
    .rom_en(rom_en),
    .rom_addr(rom_addr),
    .rom_rdata(rom_rdata),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_transparent(rsp_transparent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] rom_word(input logic [10:0] a);
    if (a == 11'h155) return 12'hFFF;
    if (a == 11'h156) return 12'hFFE;
    return {1'b0, a} ^ 12'h5A5;
  endfunction

  // one-cycle synchronous ROM
  always @(posedge clk) if (rom_en) rom_q <= rom_word(rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rs, input logic [3:0] r, input logic en, input logic [3:0] eg, input bit rsp);
    int id;
    logic [10:0] a;
    logic [11:0] w;
    @(negedge clk);
    reset = rs;
    req = r;
    arb_en = en;
    #1;
    chk("gnt", gnt, eg);
    if (eg != 0) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) id = i;
      a = {sel_a[id], addr_a[id]};
      w = rom_word(a);
      aq.push_back('{due: cyc + 1, a: a});
      if (rsp) rq.push_back('{due: cyc + 2, id: 2'(id), data: w, tr: w == 12'hFFF});
    end
  endtask

  always @(negedge clk) begin
    if (rom_en) begin
      if (aq.size() == 0) chk("rom_en_unexpected", rom_en, 0);
      else begin
        ea = aq.pop_front();
        chk("rom_cycle", cyc, ea.due);
        chk("rom_addr", rom_addr, ea.a);
      end
    end else if (aq.size() != 0 && aq[0].due <= cyc) begin
      chk("rom_en_missing", rom_en, 1);
      void'(aq.pop_front());
    end
    if (rsp_valid) begin
      if (rq.size() == 0) chk("rsp_valid_unexpected", rsp_valid, 0);
      else begin
        er = rq.pop_front();
        chk("rsp_cycle", cyc, er.due);
        chk("rsp_id", rsp_id, er.id);
        chk("rsp_data", rsp_data, er.data);
        chk("rsp_transparent", rsp_transparent, er.tr);
      end
    end else if (rq.size() != 0 && rq[0].due <= cyc) begin
      chk("rsp_valid_missing", rsp_valid, 1);
      void'(rq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 8'(8'h10 * i + 8'h05);
      sel_a[i] = 3'(i);
    end
    step(0, 4'b1111, 1, 4'b0000, 1);
    step(0, 4'b1111, 1, 4'b0000, 1);
    chk("reset_rom_en", rom_en, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
`ifdef SPRITE_ARB_PRIO_EN
    repeat (3) step(1, 4'b1011, 1, 4'b0001, 1);
    step(1, 4'b1010, 1, 4'b0010, 1);
    step(1, 4'b1010, 1, 4'b1000, 1);
    step(1, 4'b1010, 1, 4'b0010, 1);
`else
    step(1, 4'b1111, 1, 4'b0001, 1);
    step(1, 4'b1111, 1, 4'b0010, 1);
    step(1, 4'b1111, 1, 4'b0100, 1);
    step(1, 4'b1111, 1, 4'b1000, 1);
    step(1, 4'b1111, 1, 4'b0001, 1);
`endif
    step(1, 4'b0000, 1, 4'b0000, 1);
    addr_a[2] = 8'h37;
    sel_a[2] = 3'b010;
    step(1, 4'b0100, 1, 4'b0100, 1);
    repeat (2) step(1, 4'b0000, 1, 4'b0000, 1);
    addr_a[1] = 8'h55;
    sel_a[1] = 3'b001;
    addr_a[3] = 8'h56;
    sel_a[3] = 3'b001;
    step(1, 4'b1010, 1, 4'b1000, 1);
    step(1, 4'b0010, 1, 4'b0010, 1);
    repeat (2) step(1, 4'b0000, 1, 4'b0000, 1);
    step(1, 4'b0001, 1, 4'b0001, 1);
    repeat (3) step(1, 4'b1111, 0, 4'b0000, 1);
    step(1, 4'b0000, 1, 4'b0000, 1);
    step(1, 4'b0010, 0, 4'b0000, 1);
    step(1, 4'b0100, 1, 4'b0100, 1);
`ifdef SPRITE_ARB_PRIO_EN
    step(1, 4'b1111, 1, 4'b0001, 1);
`else
    step(1, 4'b1111, 1, 4'b1000, 1);
`endif
    repeat (2) step(1, 4'b0000, 1, 4'b0000, 1);
    step(1, 4'b1111, 1, 4'b0001, 0);
    step(0, 4'b0000, 1, 4'b0000, 1);
    step(0, 4'b1111, 1, 4'b0000, 1);
    step(1, 4'b1111, 1, 4'b0001, 1);
    repeat (4) step(1, 4'b0000, 1, 4'b0000, 1);
    chk("rsp_queue_drained", rq.size(), 0);
    chk("rom_queue_drained", aq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
